// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: command codes,
// ALU opcode and status encodings, FSM state constants and small helpers.
package calc_pkg;

    localparam logic [3:0] CMD_ADD  = 4'd10;
    localparam logic [3:0] CMD_SUB  = 4'd11;
    localparam logic [3:0] CMD_MUL  = 4'd12;
    localparam logic [3:0] CMD_EQ   = 4'd13;
    localparam logic [3:0] CMD_CLR  = 4'd14;
    localparam logic [3:0] CMD_BKSP = 4'd15;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_ENTRY  = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESULT = 2'd2,
        ST_ERROR  = 2'd3
    } status_e;

    typedef logic [2:0] state_t;

    localparam state_t A_ENTRY = 3'd0;
    localparam state_t OP_WAIT = 3'd1;
    localparam state_t B_ENTRY = 3'd2;
    localparam state_t LAUNCH  = 3'd3;
    localparam state_t EXEC    = 3'd4;
    localparam state_t SHOW    = 3'd5;
    localparam state_t ERR     = 3'd6;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] c);
        return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_MUL);
    endfunction

    function automatic alu_op_e cmd_to_op(input logic [3:0] c);
        alu_op_e op;
        case (c)
            CMD_SUB: op = OP_SUB;
            CMD_MUL: op = OP_MUL;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // Largest operand that fits in the given number of decimal digits.
    function automatic logic [63:0] max_operand(input int unsigned digits);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < 19; i++) begin
            if (i < int'(digits)) r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

    // Number of decimal digits in v (zero has none).
    function automatic int unsigned dec_digits(input logic [63:0] v);
        logic [63:0] p;
        int unsigned n;
        p = 64'd1;
        n = 0;
        for (int i = 0; i < 19; i++) begin
            if (v >= p) n = n + 1;
            p = p * 64'd10;
        end
        return n;
    endfunction

endpackage

// File: rtl/calc_operand_acc.sv
// One decimal operand register: shift-in of digits, backspace, clear and
// direct load, with a digit count that saturates at DIGITS.
module calc_operand_acc
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OPW    = 16,
    localparam int CNTW  = $clog2(DIGITS + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clr,
    input  logic            load,
    input  logic [OPW-1:0]  load_value,
    input  logic [CNTW-1:0] load_count,
    input  logic            shift,
    input  logic            bksp,
    input  logic [3:0]      digit,
    output logic [OPW-1:0]  value,
    output logic [CNTW-1:0] count
);

    logic [OPW-1:0]  value_q, value_d;
    logic [CNTW-1:0] count_q, count_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = '0;
            count_d = '0;
        end else if (load) begin
            value_d = load_value;
            count_d = load_count;
        end else if (shift && (count_q < CNTW'(DIGITS))) begin
            value_d = value_q * OPW'(10) + OPW'(digit);
            count_d = count_q + 1'b1;
        end else if (bksp && (count_q != '0)) begin
            value_d = value_q / OPW'(10);
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign count = count_q;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad calculator command sequencer: builds A op B, launches the ALU and
// latches result/status. Define CALC_SEQ_CHAIN_EN to chain an operator off a shown result.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int OPW     = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [3:0]       cmd,
    output logic             cmd_ready,
    output logic             alu_start,
    output logic [1:0]       alu_op,
    output logic [OPW-1:0]   alu_a,
    output logic [OPW-1:0]   alu_b,
    input  logic             alu_done,
    input  logic [2*OPW-1:0] alu_result,
    input  logic             alu_ovf,
    output logic [2*OPW-1:0] result,
    output logic [1:0]       status
);

    localparam int CNTW = $clog2(DIGITS + 1);
    localparam int WDW  = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    alu_op_e          op_q, op_d;
    logic [2*OPW-1:0] res_q, res_d;
    logic [WDW-1:0]   wd_q, wd_d, wd_inc;

    logic             a_clr, a_load, a_shift, a_bksp;
    logic [OPW-1:0]   a_load_value;
    logic [CNTW-1:0]  a_load_count;
    logic             b_clr, b_load, b_shift, b_bksp;
    logic [OPW-1:0]   a_value, b_value;
    logic [CNTW-1:0]  a_count, b_count;
    logic             accept;
    status_e          status_s;
    logic             unused_a_count;

    assign cmd_ready      = (state_q != LAUNCH) && (state_q != EXEC);
    assign accept         = cmd_valid && cmd_ready;
    assign wd_inc         = wd_q + 1'b1;
    assign unused_a_count = ^a_count;

    calc_operand_acc #(.DIGITS(DIGITS), .OPW(OPW)) u_acc_a (
        .clock      (clock),
        .reset      (reset),
        .clr        (a_clr),
        .load       (a_load),
        .load_value (a_load_value),
        .load_count (a_load_count),
        .shift      (a_shift),
        .bksp       (a_bksp),
        .digit      (cmd),
        .value      (a_value),
        .count      (a_count)
    );

    calc_operand_acc #(.DIGITS(DIGITS), .OPW(OPW)) u_acc_b (
        .clock      (clock),
        .reset      (reset),
        .clr        (b_clr),
        .load       (b_load),
        .load_value (OPW'(cmd)),
        .load_count (CNTW'(1)),
        .shift      (b_shift),
        .bksp       (b_bksp),
        .digit      (cmd),
        .value      (b_value),
        .count      (b_count)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        res_d        = res_q;
        wd_d         = wd_q;
        a_clr        = 1'b0;
        a_load       = 1'b0;
        a_load_value = OPW'(cmd);
        a_load_count = CNTW'(1);
        a_shift      = 1'b0;
        a_bksp       = 1'b0;
        b_clr        = 1'b0;
        b_load       = 1'b0;
        b_shift      = 1'b0;
        b_bksp       = 1'b0;

        case (state_q)
            A_ENTRY: if (accept) begin
                if (is_digit(cmd)) begin
                    a_shift = 1'b1;
                end else if (is_op(cmd)) begin
                    op_d    = cmd_to_op(cmd);
                    state_d = OP_WAIT;
                end else if (cmd == CMD_BKSP) begin
                    a_bksp = 1'b1;
                end
            end
            OP_WAIT: if (accept) begin
                if (is_digit(cmd)) begin
                    b_load  = 1'b1;
                    state_d = B_ENTRY;
                end else if (is_op(cmd)) begin
                    op_d = cmd_to_op(cmd);
                end
            end
            B_ENTRY: if (accept) begin
                if (is_digit(cmd)) begin
                    b_shift = 1'b1;
                end else if ((cmd == CMD_EQ) && (b_count != '0)) begin
                    state_d = LAUNCH;
                end else if (cmd == CMD_BKSP) begin
                    b_bksp = 1'b1;
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = EXEC;
            end
            EXEC: begin
                // A done in the same cycle as the watchdog expiry wins.
                if (alu_done) begin
                    res_d   = alu_ovf ? '0 : alu_result;
                    state_d = alu_ovf ? ERR : SHOW;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == WDW'(TIMEOUT)) begin
                        res_d   = '0;
                        state_d = ERR;
                    end
                end
            end
            SHOW: if (accept) begin
                if (is_digit(cmd)) begin
                    a_load  = 1'b1;
                    state_d = A_ENTRY;
                end
`ifdef CALC_SEQ_CHAIN_EN
                else if (is_op(cmd)) begin
                    if (res_q > (2*OPW)'(max_operand(DIGITS))) begin
                        res_d   = '0;
                        state_d = ERR;
                    end else begin
                        a_load       = 1'b1;
                        a_load_value = res_q[OPW-1:0];
                        a_load_count = CNTW'(dec_digits(64'(res_q[OPW-1:0])));
                        op_d         = cmd_to_op(cmd);
                        state_d      = OP_WAIT;
                    end
                end
`endif
            end
            ERR: ;
            default: state_d = A_ENTRY;
        endcase

        // Clear overrides anything decided above; never reachable in LAUNCH/EXEC.
        if (accept && (cmd == CMD_CLR)) begin
            state_d = A_ENTRY;
            a_clr   = 1'b1;
            b_clr   = 1'b1;
            res_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= A_ENTRY;
            op_q    <= OP_ADD;
            res_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        case (state_q)
            LAUNCH, EXEC: status_s = ST_BUSY;
            SHOW:         status_s = ST_RESULT;
            ERR:          status_s = ST_ERROR;
            default:      status_s = ST_ENTRY;
        endcase
    end

    always_comb begin
        case (state_q)
            B_ENTRY, LAUNCH, EXEC: result = {{OPW{1'b0}}, b_value};
            SHOW, ERR:             result = res_q;
            default:               result = {{OPW{1'b0}}, a_value};
        endcase
    end

    assign status    = status_s;
    assign alu_start = (state_q == LAUNCH);
    assign alu_op    = op_q;
    assign alu_a     = a_value;
    assign alu_b     = b_value;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: stimulus queues expected output changes
// and ALU launches; a monitor pops and compares whenever the DUT presents them.
module tb_calc_seq_ctrl;

    localparam int DIGITS  = 4;
    localparam int OPW     = 16;
    localparam int TIMEOUT = 64;

    localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12;
    localparam logic [3:0] K_EQ  = 4'd13, K_CLR = 4'd14, K_BKSP = 4'd15;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [3:0]       cmd;
    logic             cmd_ready;
    logic             alu_start;
    logic [1:0]       alu_op;
    logic [OPW-1:0]   alu_a, alu_b;
    logic             alu_done;
    logic [2*OPW-1:0] alu_result;
    logic             alu_ovf;
    logic [2*OPW-1:0] result;
    logic [1:0]       status;

    typedef struct {
        logic [1:0]       st;
        logic [2*OPW-1:0] res;
    } out_t;

    typedef struct {
        logic [1:0]     op;
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
    } start_t;

    out_t   q_out[$];
    start_t q_start[$];

    int n_cmp = 0;
    int n_bad = 0;
    int alu_mode = 0;   // 0 answer, 1 answer with overflow, 2 never answer
    bit mon_en = 1'b0;

    calc_seq_ctrl #(.DIGITS(DIGITS), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd        (cmd),
        .cmd_ready  (cmd_ready),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .result     (result),
        .status     (status)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_out(input logic [1:0] st, input logic [2*OPW-1:0] res);
        out_t e;
        e.st  = st;
        e.res = res;
        q_out.push_back(e);
    endtask

    task automatic exp_start(input logic [1:0] op, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        start_t e;
        e.op = op;
        e.a  = a;
        e.b  = b;
        q_start.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [3:0] c);
        int n = 0;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd       = c;
        while (!cmd_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_ready_timeout: cmd %0d never accepted", c);
        end
        @(posedge clock);
        #1 cmd_valid = 1'b0;
    endtask

    // Monitor: every change of {status,result} and every alu_start pulse is scored.
    initial begin
        logic [1:0]       prev_st = 2'd0;
        logic [2*OPW-1:0] prev_res = '0;
        out_t             eo;
        start_t           es;
        wait (mon_en);
        forever begin
            @(negedge clock);
            if ((status !== prev_st) || (result !== prev_res)) begin
                if (q_out.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got status %0d result 0x%0h, none expected", status, result);
                end else begin
                    eo = q_out.pop_front();
                    check("out_status", 64'(status), 64'(eo.st));
                    check("out_result", 64'(result), 64'(eo.res));
                end
                prev_st  = status;
                prev_res = result;
            end
            if (alu_start === 1'b1) begin
                if (q_start.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: got op %0d a %0d b %0d, none expected", alu_op, alu_a, alu_b);
                end else begin
                    es = q_start.pop_front();
                    check("start_op", 64'(alu_op), 64'(es.op));
                    check("start_a", 64'(alu_a), 64'(es.a));
                    check("start_b", 64'(alu_b), 64'(es.b));
                end
            end
        end
    end

    // ALU model: answers three cycles after the launch pulse.
    initial begin
        logic [2*OPW-1:0] a, b, r;
        logic [1:0]       op;
        forever begin
            @(negedge clock);
            if (alu_start === 1'b1 && alu_mode != 2) begin
                a  = (2*OPW)'(alu_a);
                b  = (2*OPW)'(alu_b);
                op = alu_op;
                case (op)
                    2'd1:    r = a - b;
                    2'd2:    r = a * b;
                    default: r = a + b;
                endcase
                repeat (3) @(negedge clock);
                alu_done   = 1'b1;
                alu_result = r;
                alu_ovf    = (alu_mode == 1);
                @(negedge clock);
                alu_done = 1'b0;
                alu_ovf  = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check({tag, "_alu_start"}, 64'(alu_start), 64'd0);
        check({tag, "_alu_op"}, 64'(alu_op), 64'd0);
        check({tag, "_alu_a"}, 64'(alu_a), 64'd0);
        check({tag, "_alu_b"}, 64'(alu_b), 64'd0);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_status"}, 64'(status), 64'd0);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = 4'd0;
        alu_done   = 1'b0;
        alu_result = '0;
        alu_ovf    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        idle(2);
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // 12 + 34 = 46
        exp_out(0, 1);  send(4'd1);
        exp_out(0, 12); send(4'd2);
        send(K_ADD);
        exp_out(0, 3);  send(4'd3);
        exp_out(0, 34); send(4'd4);
        exp_out(1, 34); exp_start(0, 12, 34); exp_out(2, 46);
        send(K_EQ);
        idle(8);

        // digit saturation at four digits, then backspace
        exp_out(0, 0);    send(K_CLR);
        exp_out(0, 1);    send(4'd1);
        exp_out(0, 12);   send(4'd2);
        exp_out(0, 123);  send(4'd3);
        exp_out(0, 1234); send(4'd4);
        send(4'd5);
        exp_out(0, 123);  send(K_BKSP);

        // 7 * = does not launch; 3 = then launches a multiply
        exp_out(0, 0); send(K_CLR);
        exp_out(0, 7); send(4'd7);
        send(K_MUL);
        send(K_EQ);
        idle(4);
        exp_out(0, 3); send(4'd3);
        exp_out(1, 3); exp_start(2, 7, 3); exp_out(2, 21);
        send(K_EQ);
        idle(8);

        // 3 - 5 = wraps to two's complement
        exp_out(0, 0); send(K_CLR);
        exp_out(0, 3); send(4'd3);
        send(K_SUB);
        exp_out(0, 5); send(4'd5);
        exp_out(1, 5); exp_start(1, 3, 5); exp_out(2, 32'hFFFF_FFFE);
        send(K_EQ);
        idle(8);

        // same again with overflow flagged, digit in ERR dropped, then clear
        alu_mode = 1;
        exp_out(0, 0); send(K_CLR);
        exp_out(0, 3); send(4'd3);
        send(K_SUB);
        exp_out(0, 5); send(4'd5);
        exp_out(1, 5); exp_start(1, 3, 5); exp_out(3, 0);
        send(K_EQ);
        idle(8);
        send(4'd9);
        idle(2);
        exp_out(0, 0); send(K_CLR);

        // watchdog: ALU never answers
        alu_mode = 2;
        exp_out(0, 8); send(4'd8);
        send(K_ADD);
        exp_out(0, 1); send(4'd1);
        exp_out(1, 1); exp_start(0, 8, 1); exp_out(3, 0);
        send(K_EQ);
        n = 0;
        while (n < TIMEOUT + 20 && status !== 2'd3) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 2) begin
                check("exec_cmd_ready", 64'(cmd_ready), 64'd0);
                cmd_valid = 1'b1;
                cmd       = 4'd5;
            end
        end
        cmd_valid = 1'b0;
        check("timeout_cycles", 64'(n - 1), 64'(TIMEOUT));
        exp_out(0, 0); send(K_CLR);

        // reset mid-EXEC, then a late done must be ignored
        exp_out(0, 6); send(4'd6);
        send(K_MUL);
        exp_out(0, 2); send(4'd2);
        exp_out(1, 2); exp_start(2, 6, 2);
        send(K_EQ);
        idle(4);
        check("exec_busy_status", 64'(status), 64'd1);
        exp_out(0, 0);
        reset = 1'b0;
        @(negedge clock);
        #1;
        check_reset_outputs("midexec");
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        alu_done   = 1'b1;
        alu_result = 32'd99;
        @(negedge clock) alu_done = 1'b0;
        idle(3);
        check("late_done_status", 64'(status), 64'd0);

        // operator after a shown result
        alu_mode = 0;
        exp_out(0, 2); send(4'd2);
        send(K_ADD);
        exp_out(0, 3); send(4'd3);
        exp_out(1, 3); exp_start(0, 2, 3); exp_out(2, 5);
        send(K_EQ);
        idle(8);
`ifdef CALC_SEQ_CHAIN_EN
        exp_out(0, 5); send(K_ADD);
        exp_out(0, 4); send(4'd4);
        exp_out(1, 4); exp_start(0, 5, 4); exp_out(2, 9);
        send(K_EQ);
        idle(8);
`else
        send(K_ADD);
        idle(3);
        check("chain_off_status", 64'(status), 64'd2);
        exp_out(0, 4); send(4'd4);
`endif

        idle(10);
        check("out_queue_empty", 64'(q_out.size()), 64'd0);
        check("start_queue_empty", 64'(q_start.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
